// File: rtl/max7219_rcv_pkg.sv
// Shared constants and types for the MAX7219 receive-side model.
// Holds register addresses, packet layout and FSM encodings.
package max7219_rcv_pkg;

    localparam int unsigned PKT_W      = 16;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SEG_W      = NUM_DIGITS * DATA_W;

    // Packet field positions (MSB-first on the wire)
    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned RSVD_LSB = 12;

    localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;

    localparam logic [ADDR_W-1:0] ADDR_NOOP   = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_DIG0   = 4'h1;
    localparam logic [ADDR_W-1:0] ADDR_DIG1   = 4'h2;
    localparam logic [ADDR_W-1:0] ADDR_DIG2   = 4'h3;
    localparam logic [ADDR_W-1:0] ADDR_DIG3   = 4'h4;
    localparam logic [ADDR_W-1:0] ADDR_DIG4   = 4'h5;
    localparam logic [ADDR_W-1:0] ADDR_DIG5   = 4'h6;
    localparam logic [ADDR_W-1:0] ADDR_DIG6   = 4'h7;
    localparam logic [ADDR_W-1:0] ADDR_DIG7   = 4'h8;
    localparam logic [ADDR_W-1:0] ADDR_DECODE = 4'h9;
    localparam logic [ADDR_W-1:0] ADDR_INTENS = 4'hA;
    localparam logic [ADDR_W-1:0] ADDR_SCAN   = 4'hB;
    localparam logic [ADDR_W-1:0] ADDR_SHDN   = 4'hC;
    localparam logic [ADDR_W-1:0] ADDR_TEST   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]        rsvd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pkt_t;

    // Digit registers are addressed 1..8; map to 0-based slot
    function automatic logic [2:0] digit_idx(input logic [ADDR_W-1:0] addr);
        return 3'(addr - 4'd1);
    endfunction

endpackage

// File: rtl/max7219_rcv_if.sv
// Serial link between the seven-segment driver and the receiver.
interface max7219_rcv_if;
    logic sclk;
    logic load;
    logic sdi;

    modport master (output sclk, output load, output sdi);
    modport slave  (input  sclk, input  load, input  sdi);
endinterface

// File: rtl/max7219_rcv_sync_edge.sv
// Multi-stage synchronizer with a history flop for single-cycle edge strobes.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_c =  sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_c = ~sync_q[SYNC_STAGES-1] &  hist_q;

endmodule

// File: rtl/max7219_rcv.sv
// MAX7219 receive-side model: reassembles serial frames and keeps a
// MAX7219-style register file for loopback checking and emulation.
module max7219_rcv
    import max7219_rcv_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    max7219_rcv_if.slave       ser,
    output logic [SEG_W-1:0]   seg,
    output logic [DATA_W-1:0]  decode,
    output logic [3:0]         intensity,
    output logic [2:0]         scan_lim,
    output logic               shdn,
    output logic               test,
    output logic [PKT_W-1:0]   pkt,
    output logic               pkt_vld,
    output logic               frm_err
);

    logic sclk_lvl_unused, sclk_rise, sclk_fall_unused;
    logic load_lvl_unused, load_rise, load_fall;
    logic sdi_lvl, sdi_rise_unused, sdi_fall_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .din    (ser.sclk),
        .level  (sclk_lvl_unused),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
        .clk    (clk),
        .rst    (rst),
        .din    (ser.load),
        .level  (load_lvl_unused),
        .rise_c (load_rise),
        .fall_c (load_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk    (clk),
        .rst    (rst),
        .din    (ser.sdi),
        .level  (sdi_lvl),
        .rise_c (sdi_rise_unused),
        .fall_c (sdi_fall_unused)
    );

    state_t            state;
    pkt_t              shift_reg;
    logic [CNT_W-1:0]  bit_cnt;

    // Frame FSM and register file; a load rise takes priority over a coincident sclk rise
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            seg       <= '0;
            decode    <= '0;
            intensity <= '0;
            scan_lim  <= '0;
            shdn      <= 1'b1;
            test      <= 1'b0;
            pkt       <= '0;
            pkt_vld   <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            pkt_vld <= 1'b0;
            frm_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_fall) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (load_rise) begin
                        state <= ST_LATCH;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[PKT_W-2:0], sdi_lvl};
                        if (bit_cnt != CNT_MAX) begin
                            bit_cnt <= 5'(bit_cnt + 5'd1);
                        end
                    end
                end
                ST_LATCH: begin
                    state <= ST_IDLE;
                    if (bit_cnt >= 5'(PKT_W)) begin
                        pkt     <= shift_reg;
                        pkt_vld <= 1'b1;
                        case (shift_reg.addr)
                            ADDR_DIG0, ADDR_DIG1, ADDR_DIG2, ADDR_DIG3,
                            ADDR_DIG4, ADDR_DIG5, ADDR_DIG6, ADDR_DIG7:
                                seg[{digit_idx(shift_reg.addr), 3'b000} +: DATA_W] <= shift_reg.data;
                            ADDR_DECODE: decode    <= shift_reg.data;
                            ADDR_INTENS: intensity <= shift_reg.data[3:0];
                            ADDR_SCAN:   scan_lim  <= shift_reg.data[2:0];
                            ADDR_SHDN:   shdn      <= ~shift_reg.data[0];
                            ADDR_TEST:   test      <= shift_reg.data[0];
                            ADDR_NOOP:   ;
                            default:     ;
                        endcase
                    end else begin
                        frm_err <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_max7219_rcv.sv
// Directed bench for max7219_rcv: drives serial frames and checks outputs.
module tb_max7219_rcv;

    logic        clk;
    logic        rst;
    logic [63:0] seg;
    logic [7:0]  decode;
    logic [3:0]  intensity;
    logic [2:0]  scan_lim;
    logic        shdn;
    logic        test;
    logic [15:0] pkt;
    logic        pkt_vld;
    logic        frm_err;

    int checks = 0;
    int errors = 0;
    int vld_cnt, err_cnt, vld_pos, err_pos;

    max7219_rcv_if ser ();

    max7219_rcv #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser       (ser.slave),
        .seg       (seg),
        .decode    (decode),
        .intensity (intensity),
        .scan_lim  (scan_lim),
        .shdn      (shdn),
        .test      (test),
        .pkt       (pkt),
        .pkt_vld   (pkt_vld),
        .frm_err   (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count result pulses over n cycles, recording the first pulse position
    task automatic watch(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (pkt_vld === 1'b1) begin
                if (vld_pos < 0) vld_pos = k;
                vld_cnt++;
            end
            if (frm_err === 1'b1) begin
                if (err_pos < 0) err_pos = k;
                err_cnt++;
            end
        end
    endtask

    task automatic clear_counts();
        vld_cnt = 0; err_cnt = 0; vld_pos = -1; err_pos = -1;
    endtask

    task automatic start_frame();
        ser.sclk = 1'b0;
        ser.load = 1'b0;
        wait_clk(4);
    endtask

    task automatic shift_bit(input logic b);
        ser.sdi  = b;
        ser.sclk = 1'b0;
        wait_clk(4);
        ser.sclk = 1'b1;
        wait_clk(4);
    endtask

    task automatic shift_bits(input logic [31:0] val, input int n);
        logic [31:0] v;
        v = val;
        for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
    endtask

    // Raise load; with coincide set, an sclk rise carrying sdi=1 lands on the same edge
    task automatic close_frame(input bit coincide);
        ser.sclk = 1'b0;
        wait_clk(4);
        clear_counts();
        if (coincide) begin
            ser.sdi  = 1'b1;
            ser.sclk = 1'b1;
        end
        ser.load = 1'b1;
        watch(8);
        ser.sclk = 1'b0;
        wait_clk(4);
    endtask

    task automatic frame(input logic [31:0] val, input int n);
        start_frame();
        shift_bits(val, n);
        close_frame(1'b0);
    endtask

    int total_vld;

    initial begin
        rst = 1'b1;
        ser.sclk = 1'b0;
        ser.load = 1'b1;
        ser.sdi  = 1'b0;
        wait_clk(3);

        chk("rst_seg",       64'(seg),       64'h0);
        chk("rst_decode",    64'(decode),    64'h0);
        chk("rst_intensity", 64'(intensity), 64'h0);
        chk("rst_scan",      64'(scan_lim),  64'h0);
        chk("rst_shdn",      64'(shdn),      64'h1);
        chk("rst_test",      64'(test),      64'h0);
        chk("rst_pkt",       64'(pkt),       64'h0);

        frame(32'h0C01, 16);
        chk("rst_frame_vld", 64'(vld_cnt), 64'd0);
        chk("rst_frame_err", 64'(err_cnt), 64'd0);
        chk("rst_frame_shdn", 64'(shdn),   64'h1);
        chk("rst_frame_pkt",  64'(pkt),    64'h0);
        rst = 1'b0;
        wait_clk(4);

        frame(32'h0C01, 16);
        chk("wr_vld_cnt", 64'(vld_cnt), 64'd1);
        chk("wr_vld_lat", 64'(vld_pos), 64'd3);
        chk("wr_err_cnt", 64'(err_cnt), 64'd0);
        chk("wr_pkt",     64'(pkt),     64'h0C01);
        chk("wr_shdn",    64'(shdn),    64'h0);
        chk("wr_seg",     64'(seg),     64'h0);
        chk("wr_intens",  64'(intensity), 64'h0);
        chk("wr_test",    64'(test),    64'h0);

        total_vld = 0;
        for (int k = 1; k <= 8; k++) begin
            frame(32'((k << 8) | (k * 8'h11)), 16);
            total_vld += vld_cnt;
        end
        chk("dig_vld_total", 64'(total_vld), 64'd8);
        chk("dig_seg",       64'(seg),       64'h8877665544332211);
        chk("dig_pkt",       64'(pkt),       64'h0888);

        frame(32'h0000, 16);
        chk("noop_vld", 64'(vld_cnt), 64'd1);
        chk("noop_pkt", 64'(pkt),     64'h0000);
        chk("noop_seg", 64'(seg),     64'h8877665544332211);

        frame(32'h0ABC, 12);
        chk("short_err_cnt", 64'(err_cnt), 64'd1);
        chk("short_err_lat", 64'(err_pos), 64'd3);
        chk("short_vld",     64'(vld_cnt), 64'd0);
        chk("short_pkt",     64'(pkt),     64'h0000);
        chk("short_intens",  64'(intensity), 64'h0);

        frame(32'h0A07, 16);
        chk("intens_vld", 64'(vld_cnt),   64'd1);
        chk("intens_val", 64'(intensity), 64'h7);
        chk("intens_pkt", 64'(pkt),       64'h0A07);

        frame(32'hA0B05, 20);
        chk("long_vld",  64'(vld_cnt),  64'd1);
        chk("long_err",  64'(err_cnt),  64'd0);
        chk("long_pkt",  64'(pkt),      64'h0B05);
        chk("long_scan", 64'(scan_lim), 64'h5);

        frame(32'hF905, 16);
        chk("hinib_decode", 64'(decode), 64'h05);
        chk("hinib_pkt",    64'(pkt),    64'hF905);
        chk("hinib_seg",    64'(seg),    64'h8877665544332211);

        // Reset after 8 bits: frame is abandoned and the closing load rise is ignored
        start_frame();
        shift_bits(32'h0C, 8);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        shift_bits(32'h00, 8);
        close_frame(1'b0);
        chk("midrst_vld",  64'(vld_cnt), 64'd0);
        chk("midrst_err",  64'(err_cnt), 64'd0);
        chk("midrst_seg",  64'(seg),     64'h0);
        chk("midrst_shdn", 64'(shdn),    64'h1);
        chk("midrst_pkt",  64'(pkt),     64'h0);

        frame(32'h0F01, 16);
        chk("test_vld", 64'(vld_cnt), 64'd1);
        chk("test_val", 64'(test),    64'h1);
        chk("test_pkt", 64'(pkt),     64'h0F01);

        start_frame();
        shift_bits(32'h0F00, 16);
        close_frame(1'b1);
        chk("coin_vld",  64'(vld_cnt), 64'd1);
        chk("coin_pkt",  64'(pkt),     64'h0F00);
        chk("coin_test", 64'(test),    64'h0);

        clear_counts();
        for (int i = 0; i < 4; i++) begin
            ser.sdi  = 1'(i);
            ser.sclk = 1'b1;
            watch(4);
            ser.sclk = 1'b0;
            watch(4);
        end
        chk("idle_sclk_vld", 64'(vld_cnt), 64'd0);
        chk("idle_sclk_err", 64'(err_cnt), 64'd0);
        chk("idle_sclk_pkt", 64'(pkt),     64'h0F00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
